// File: rtl/keypad_value_entry.sv
// Keypad snapshot to decimal value entry and waveform-mode selection.
// Emits the committed value and mode for the generator, and the live entry for the display.
module keypad_value_entry #(
    parameter int N_COLUMN = 4,
    parameter int N_ROW    = 4,
    parameter int N_DIGITS = 6,
    parameter int VALUE_W  = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_COLUMN*N_ROW-1:0] out_keys,
    input  logic                      data_valid,
    output logic [VALUE_W-1:0]        live_value,
    output logic [3:0]                digit_count,
    output logic                      entry_active,
    output logic [VALUE_W-1:0]        value_out,
    output logic                      value_valid,
    output logic [1:0]                mode_out,
    output logic                      mode_valid
);

    localparam int NK = N_COLUMN * N_ROW;

    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [NK-1:0]        r_snap;
    logic [VALUE_W-1:0]   r_live, w_live_nxt;
    logic [3:0]           r_cnt, w_cnt_nxt;
    logic [VALUE_W-1:0]   r_vout, w_vout_nxt;
    logic                 r_vvalid, w_vvalid_nxt;
    logic [1:0]           r_mode, w_mode_nxt;
    logic                 r_mvalid, w_mvalid_nxt;

    logic                 w_onehot;
    logic                 w_press;
    logic [7:0]           w_idx;
    logic                 w_is_digit;
    logic [3:0]           w_digit;
    logic                 w_is_clr;
    logic                 w_is_ent;
    logic                 w_is_mode;
    logic [1:0]           w_mode;
    logic [VALUE_W-1:0]   w_times10;

    // A press needs a single key and a fully released previous scan.
    assign w_onehot = (out_keys != '0) &&
                      ((out_keys & (out_keys - NK'(1))) == '0);
    assign w_press  = data_valid && w_onehot && (r_snap == '0);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NK; i++) begin
            if (out_keys[i]) w_idx = 8'(i);
        end
    end

    always_comb begin
        w_is_digit = 1'b0;
        w_digit    = 4'd0;
        w_is_clr   = 1'b0;
        w_is_ent   = 1'b0;
        w_is_mode  = 1'b0;
        w_mode     = 2'd0;
        case (w_idx)
            8'd0:  begin w_is_digit = 1'b1; w_digit = 4'd1; end
            8'd1:  begin w_is_digit = 1'b1; w_digit = 4'd2; end
            8'd2:  begin w_is_digit = 1'b1; w_digit = 4'd3; end
            8'd4:  begin w_is_digit = 1'b1; w_digit = 4'd4; end
            8'd5:  begin w_is_digit = 1'b1; w_digit = 4'd5; end
            8'd6:  begin w_is_digit = 1'b1; w_digit = 4'd6; end
            8'd8:  begin w_is_digit = 1'b1; w_digit = 4'd7; end
            8'd9:  begin w_is_digit = 1'b1; w_digit = 4'd8; end
            8'd10: begin w_is_digit = 1'b1; w_digit = 4'd9; end
            8'd13: begin w_is_digit = 1'b1; w_digit = 4'd0; end
            8'd12: w_is_clr = 1'b1;
            8'd14: w_is_ent = 1'b1;
            8'd3, 8'd7, 8'd11, 8'd15: begin
                w_is_mode = 1'b1;
                w_mode    = w_idx[3:2];
            end
            default: ;
        endcase
    end

    assign w_times10 = (r_live << 3) + (r_live << 1);

    always_comb begin
        w_state_nxt  = r_state;
        w_live_nxt   = r_live;
        w_cnt_nxt    = r_cnt;
        w_vout_nxt   = r_vout;
        w_vvalid_nxt = 1'b0;
        w_mode_nxt   = r_mode;
        w_mvalid_nxt = 1'b0;
        if (w_press) begin
            if (w_is_digit) begin
                if (r_state == IDLE) begin
                    w_live_nxt  = VALUE_W'(w_digit);
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = ENTRY;
                end else if (r_cnt < 4'(N_DIGITS)) begin
                    w_live_nxt = w_times10 + VALUE_W'(w_digit);
                    w_cnt_nxt  = r_cnt + 4'd1;
                end
            end else if (w_is_ent) begin
                if (r_state == ENTRY) begin
                    w_vout_nxt   = r_live;
                    w_vvalid_nxt = 1'b1;
                    w_live_nxt   = '0;
                    w_cnt_nxt    = 4'd0;
                    w_state_nxt  = IDLE;
                end
            end else if (w_is_clr) begin
                w_live_nxt  = '0;
                w_cnt_nxt   = 4'd0;
                w_state_nxt = IDLE;
            end else if (w_is_mode) begin
                w_mode_nxt   = w_mode;
                w_mvalid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_snap   <= '0;
            r_live   <= '0;
            r_cnt    <= 4'd0;
            r_vout   <= '0;
            r_vvalid <= 1'b0;
            r_mode   <= 2'd0;
            r_mvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            if (data_valid) r_snap <= out_keys;
            r_live   <= w_live_nxt;
            r_cnt    <= w_cnt_nxt;
            r_vout   <= w_vout_nxt;
            r_vvalid <= w_vvalid_nxt;
            r_mode   <= w_mode_nxt;
            r_mvalid <= w_mvalid_nxt;
        end
    end

    assign live_value   = r_live;
    assign digit_count  = r_cnt;
    assign entry_active = (r_state == ENTRY);
    assign value_out    = r_vout;
    assign value_valid  = r_vvalid;
    assign mode_out     = r_mode;
    assign mode_valid   = r_mvalid;

endmodule
